// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - instruction memory with byte-stream boot loader and debug write port
module imem_boot_loader #(
  parameter int          DEPTH    = 4096,
  parameter int          ADDR_W   = 32,
  parameter int          LEN_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic              r_req_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic [31:0]       r_data_o,
  output logic              r_valid_o,
  output logic              r_err_o,
  input  logic              w_ena_i,
  input  logic [3:0]        w_be_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [31:0]       w_data_i,
  input  logic              ld_start_i,
  input  logic [ADDR_W-1:0] ld_base_i,
  input  logic [LEN_W-1:0]  ld_len_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  output logic              ld_ready_o,
  output logic              busy_o,
  output logic              ld_done_o,
  output logic              ld_ovf_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_W - 2;
  // Wide enough that base + word count can never wrap back into range.
  localparam int FW    = ((WA_W > LEN_W) ? WA_W : LEN_W) + 1;
  localparam logic [FW-1:0] DEPTH_FW = FW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  logic [31:0]      mem [DEPTH];
  state_t           state;
  logic [WA_W-1:0]  base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wcnt;
  logic [1:0]       bcnt;
  logic [31:0]      pack;

  logic             r_in_range, r_misaligned;
  logic [IDX_W-1:0] r_idx;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic [FW-1:0]    ld_full;
  logic             ld_in_range;
  logic [IDX_W-1:0] ld_idx;
  logic             ld_we, dw_we;
  logic             more_words;
  logic             unused_bits;

  assign unused_bits = ^{w_addr_i[1:0], ld_base_i[1:0]};

  // Address decode for the fetch, direct-write and loader paths
  always_comb begin
    r_in_range   = FW'(r_addr_i[ADDR_W-1:2]) < DEPTH_FW;
    r_misaligned = |r_addr_i[1:0];
    r_idx        = r_addr_i[IDX_W+1:2];
    w_in_range   = FW'(w_addr_i[ADDR_W-1:2]) < DEPTH_FW;
    w_idx        = w_addr_i[IDX_W+1:2];
    ld_full      = FW'(base_q) + FW'(wcnt);
    ld_in_range  = ld_full < DEPTH_FW;
    ld_idx       = ld_full[IDX_W-1:0];
    ld_we        = (state == WRITE) && ld_in_range && !rst;
    dw_we        = w_ena_i && !busy_o && w_in_range && !rst;
    more_words   = ({1'b0, wcnt} + (LEN_W+1)'(1)) < {1'b0, len_q};
  end

  // Memory array: loader word store has priority; direct writes only happen while idle anyway
  always_ff @(posedge clk_100MHz) begin
    if (ld_we) begin
      mem[ld_idx] <= pack;
    end else if (dw_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be_i[b]) mem[w_idx][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

  // Registered fetch port; nonblocking read gives old data on a same-cycle write
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_data_o  <= NOP_WORD;
      r_valid_o <= 1'b0;
      r_err_o   <= 1'b0;
    end else if (r_req_i && !busy_o) begin
      r_valid_o <= 1'b1;
      if (r_misaligned || !r_in_range) begin
        r_data_o <= NOP_WORD;
        r_err_o  <= 1'b1;
      end else begin
        r_data_o <= mem[r_idx];
        r_err_o  <= 1'b0;
      end
    end else begin
      r_valid_o <= 1'b0;
      r_err_o   <= 1'b0;
    end
  end

  // Loader FSM with its handshake/status outputs registered alongside the state
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      wcnt       <= '0;
      bcnt       <= '0;
      pack       <= '0;
      ld_ready_o <= 1'b0;
      busy_o     <= 1'b0;
      ld_done_o  <= 1'b0;
      ld_ovf_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ld_done_o <= 1'b0;
          if (ld_start_i) begin
            base_q   <= ld_base_i[ADDR_W-1:2];
            len_q    <= ld_len_i;
            wcnt     <= '0;
            bcnt     <= '0;
            ld_ovf_o <= 1'b0;
            if (ld_len_i != '0) begin
              state      <= LOAD;
              ld_ready_o <= 1'b1;
              busy_o     <= 1'b1;
            end else begin
              state     <= DONE;
              ld_done_o <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (ld_valid_i && ld_ready_o) begin
            pack[8*bcnt +: 8] <= ld_byte_i;
            bcnt              <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              state      <= WRITE;
              ld_ready_o <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (!ld_in_range) ld_ovf_o <= 1'b1;
          wcnt <= wcnt + LEN_W'(1);
          if (more_words) begin
            state      <= LOAD;
            ld_ready_o <= 1'b1;
          end else begin
            state     <= DONE;
            busy_o    <= 1'b0;
            ld_done_o <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ld_done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_100MHz;
  logic        rst;
  logic        r_req;
  logic [31:0] r_addr;
  logic        w_ena;
  logic [3:0]  w_be;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        ld_start;
  logic [31:0] ld_base;
  logic [15:0] ld_len;
  logic        ld_valid;
  logic [7:0]  ld_byte;

  logic [31:0] a_data, b_data;
  logic        a_valid, a_err, a_ready, a_busy, a_done, a_ovf;
  logic        b_valid, b_err, b_ready, b_busy, b_done, b_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  int d0, d1;

  imem_boot_loader #(.DEPTH(4096)) dut_a (
    .clk_100MHz(clk_100MHz), .rst(rst),
    .r_req_i(r_req), .r_addr_i(r_addr), .r_data_o(a_data), .r_valid_o(a_valid), .r_err_o(a_err),
    .w_ena_i(w_ena), .w_be_i(w_be), .w_addr_i(w_addr), .w_data_i(w_data),
    .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_len_i(ld_len),
    .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_ready_o(a_ready),
    .busy_o(a_busy), .ld_done_o(a_done), .ld_ovf_o(a_ovf)
  );

  imem_boot_loader #(.DEPTH(16)) dut_b (
    .clk_100MHz(clk_100MHz), .rst(rst),
    .r_req_i(r_req), .r_addr_i(r_addr), .r_data_o(b_data), .r_valid_o(b_valid), .r_err_o(b_err),
    .w_ena_i(w_ena), .w_be_i(w_be), .w_addr_i(w_addr), .w_data_i(w_data),
    .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_len_i(ld_len),
    .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_ready_o(b_ready),
    .busy_o(b_busy), .ld_done_o(b_done), .ld_ovf_o(b_ovf)
  );

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  always @(posedge clk_100MHz) begin
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    r_req  = 1'b1;
    r_addr = a;
    tick();
    r_req  = 1'b0;
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    w_ena  = 1'b1;
    w_addr = a;
    w_be   = be;
    w_data = d;
    tick();
    w_ena  = 1'b0;
  endtask

  task automatic load_start(input logic [31:0] base, input logic [15:0] len);
    ld_start = 1'b1;
    ld_base  = base;
    ld_len   = len;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit sent = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = b;
    for (int i = 0; i < 20 && !sent; i++) begin
      if (a_ready) sent = 1'b1;
      tick();
    end
    ld_valid = 1'b0;
    if (!sent) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; r_req = 1'b0; r_addr = '0; w_ena = 1'b0; w_be = '0; w_addr = '0; w_data = '0;
    ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_byte = '0;
    tick(); tick();
    check_eq("rst_r_data", a_data, NOP);
    check_eq("rst_r_valid", {31'd0, a_valid}, 32'd0);
    check_eq("rst_r_err", {31'd0, a_err}, 32'd0);
    check_eq("rst_busy", {31'd0, a_busy}, 32'd0);
    check_eq("rst_ready", {31'd0, a_ready}, 32'd0);
    check_eq("rst_done", {31'd0, a_done}, 32'd0);
    check_eq("rst_ovf", {31'd0, a_ovf}, 32'd0);
    rst = 1'b0;
    tick();

    // T1: two-word load at 0x100
    d0 = a_done_cnt;
    load_start(32'h100, 16'd2);
    check_eq("t1_busy", {31'd0, a_busy}, 32'd1);
    check_eq("t1_ready", {31'd0, a_ready}, 32'd1);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    check_eq("t1_write_ready", {31'd0, a_ready}, 32'd0);
    check_eq("t1_write_busy", {31'd0, a_busy}, 32'd1);
    send_byte(8'h93); send_byte(8'h05); send_byte(8'h20); send_byte(8'h00);
    repeat (4) tick();
    check_eq("t1_done_pulses", a_done_cnt - d0, 32'd1);
    check_eq("t1_idle_busy", {31'd0, a_busy}, 32'd0);
    check_eq("t1_ovf", {31'd0, a_ovf}, 32'd0);

    // T2: fetches
    fetch(32'h100);
    check_eq("t2_w0", a_data, 32'h0010_0513);
    fetch(32'h104);
    check_eq("t2_w1_valid", {31'd0, a_valid}, 32'd1);
    check_eq("t2_w1_err", {31'd0, a_err}, 32'd0);
    check_eq("t2_w1", a_data, 32'h0020_0593);
    fetch(32'h102);
    check_eq("t2_mis_valid", {31'd0, a_valid}, 32'd1);
    check_eq("t2_mis_err", {31'd0, a_err}, 32'd1);
    check_eq("t2_mis_data", a_data, NOP);
    fetch(32'h104);
    tick();
    check_eq("t2_noreq_valid", {31'd0, a_valid}, 32'd0);
    check_eq("t2_noreq_hold", a_data, 32'h0020_0593);
    fetch(32'h4000);
    check_eq("t2_oor_err", {31'd0, a_err}, 32'd1);
    check_eq("t2_oor_data", a_data, NOP);

    // T3: byte-masked direct write and read-first
    dwrite(32'h14, 4'b1111, 32'hAABB_CCDD);
    dwrite(32'h14, 4'b0101, 32'h1122_3344);
    fetch(32'h14);
    check_eq("t3_masked", a_data, 32'hAA22_CC44);
    w_ena = 1'b1; w_addr = 32'h14; w_be = 4'hF; w_data = 32'h5566_7788;
    fetch(32'h14);
    w_ena = 1'b0;
    check_eq("t3_read_first", a_data, 32'hAA22_CC44);
    fetch(32'h14);
    check_eq("t3_after_write", a_data, 32'h5566_7788);
    // no aliasing of an out-of-range direct write on the small memory
    dwrite(32'h0, 4'hF, 32'h0BAD_F00D);
    dwrite(32'h40, 4'hF, 32'h1234_5678);
    fetch(32'h0);
    check_eq("t3_no_alias", b_data, 32'h0BAD_F00D);

    // T4: fetch and direct write refused during LOAD, gaps in the byte stream
    load_start(32'h200, 16'd1);
    send_byte(8'hEF); send_byte(8'hBE);
    repeat (3) tick();
    check_eq("t4_gap_ready", {31'd0, a_ready}, 32'd1);
    fetch(32'h14);
    check_eq("t4_refused", {31'd0, a_valid}, 32'd0);
    dwrite(32'h14, 4'hF, 32'h0000_0000);
    send_byte(8'hAD); send_byte(8'hDE);
    repeat (4) tick();
    fetch(32'h200);
    check_eq("t4_loaded", a_data, 32'hDEAD_BEEF);
    fetch(32'h14);
    check_eq("t4_dw_dropped", a_data, 32'h5566_7788);

    // T5: overflow on the DEPTH=16 instance
    d1 = b_done_cnt;
    load_start(32'h3C, 16'd2);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    repeat (4) tick();
    check_eq("t5_ovf", {31'd0, b_ovf}, 32'd1);
    check_eq("t5_big_no_ovf", {31'd0, a_ovf}, 32'd0);
    check_eq("t5_done", b_done_cnt - d1, 32'd1);
    fetch(32'h3C);
    check_eq("t5_idx15", b_data, 32'h0403_0201);
    fetch(32'h40);
    check_eq("t5_oor_err", {31'd0, b_err}, 32'd1);
    check_eq("t5_oor_data", b_data, NOP);

    // T6: reset mid-load, then zero-length load
    dwrite(32'h184, 4'hF, 32'hCAFE_F00D);
    load_start(32'h180, 16'd2);
    check_eq("t6_ovf_cleared", {31'd0, b_ovf}, 32'd0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_rst_busy", {31'd0, a_busy}, 32'd0);
    check_eq("t6_rst_ready", {31'd0, a_ready}, 32'd0);
    check_eq("t6_rst_ovf_b", {31'd0, b_ovf}, 32'd0);
    fetch(32'h180);
    check_eq("t6_kept", a_data, 32'h4433_2211);
    fetch(32'h184);
    check_eq("t6_untouched", a_data, 32'hCAFE_F00D);
    d0 = a_done_cnt;
    load_start(32'h0, 16'd0);
    check_eq("t6_zero_busy", {31'd0, a_busy}, 32'd0);
    repeat (3) tick();
    check_eq("t6_zero_done", a_done_cnt - d0, 32'd1);
    check_eq("t6_zero_idle_done", {31'd0, a_done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
